// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: elastic operand unpacker with a 2-entry skid FIFO and a saturating special-operand counter
module fp_unpack_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign_a,
    output logic                   sign_b,
    output logic [EXP_W-1:0]       exp_a,
    output logic [EXP_W-1:0]       exp_b,
    output logic [MAN_W:0]         sig_a,
    output logic [MAN_W:0]         sig_b,
    output logic [2:0]             class_a,
    output logic [2:0]             class_b,
    output logic [CNT_W-1:0]       special_cnt,
    input  logic                   cnt_clr
);
    localparam int W = 1 + EXP_W + MAN_W;
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
        logic [2:0]       cls;
    } op_t;
    typedef struct packed {
        op_t a;
        op_t b;
    } pair_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    function automatic op_t unpack(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             e_zero;
        logic             m_zero;
        op_t              o;
        e = x[W-2:MAN_W];
        m = x[MAN_W-1:0];
        e_zero = (e == '0);
        m_zero = (m == '0);
        o.sign = x[W-1];
        o.cls = e_zero ? (m_zero ? 3'd0 : 3'd1) : !(&e) ? 3'd2 : m_zero ? 3'd3 : m[MAN_W-1] ? 3'd4 : 3'd5;
        o.exp = e_zero ? (m_zero ? '0 : EXP_W'(1)) : e;
        o.sig = {!e_zero, m};
        return o;
    endfunction
    state_t           state, state_n;
    logic             rdy_q;
    logic             wr_ptr, rd_ptr;
    pair_t            mem [2];
    pair_t            in_pair, head;
    logic             accept, emit;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    assign in_pair   = '{a: unpack(in_a), b: unpack(in_b)};
    assign in_ready  = rdy_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && rdy_q;
    assign emit      = out_valid && out_ready;
    always_comb begin
        state_n = state;
        state_n = (state == EMPTY) ? (accept ? ONE : EMPTY)
                : (state == ONE)   ? ((accept && !emit) ? FULL : (emit && !accept) ? EMPTY : ONE)
                :                    (emit ? ONE : FULL);
    end
    // Counter widened by one bit so an overflowing +1/+2 step clamps instead of wrapping
    assign inc   = {1'b0, in_pair.a.cls >= 3'd3} + {1'b0, in_pair.b.cls >= 3'd3};
    assign sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    assign cnt_n = cnt_clr ? '0 : !accept ? cnt_q : sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            rdy_q  <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_n;
            rdy_q  <= (state_n != FULL);
            cnt_q  <= cnt_n;
            if (accept) begin
                mem[wr_ptr] <= in_pair;
                wr_ptr      <= !wr_ptr;
            end
            if (emit) rd_ptr <= !rd_ptr;
        end
    end
    assign head        = mem[rd_ptr];
    assign sign_a      = head.a.sign;
    assign exp_a       = head.a.exp;
    assign sig_a       = head.a.sig;
    assign class_a     = head.a.cls;
    assign sign_b      = head.b.sign;
    assign exp_b       = head.b.exp;
    assign sig_b       = head.b.sig;
    assign class_b     = head.b.cls;
    assign special_cnt = cnt_q;
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe: directed scoreboard bench for fp_unpack_pipe
module tb_fp_unpack_pipe;
    typedef struct packed {
        logic        sa;
        logic [7:0]  ea;
        logic [23:0] ga;
        logic [2:0]  ca;
        logic        sb;
        logic [7:0]  eb;
        logic [23:0] gb;
        logic [2:0]  cb;
    } exp_t;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, out_ready = 1, cnt_clr = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic        in_ready, out_valid, sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] sig_a, sig_b;
    logic [2:0]  class_a, class_b;
    logic [15:0] special_cnt;
    logic        v2 = 0;
    logic [31:0] a2 = 32'h7FC00000, b2 = 32'h7FC00001;
    logic        rdy2, ov2, sa2, sb2;
    logic [7:0]  ea2, eb2;
    logic [23:0] ga2, gb2;
    logic [2:0]  ca2, cb2;
    logic [1:0]  cnt2;
    exp_t        sb_q[$];
    int          n_cmp = 0, n_bad = 0;
    fp_unpack_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .sig_a(sig_a), .sig_b(sig_b), .class_a(class_a), .class_b(class_b),
        .special_cnt(special_cnt), .cnt_clr(cnt_clr)
    );
    fp_unpack_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .out_valid(ov2), .out_ready(1'b1),
        .sign_a(sa2), .sign_b(sb2), .exp_a(ea2), .exp_b(eb2),
        .sig_a(ga2), .sig_b(gb2), .class_a(ca2), .class_b(cb2),
        .special_cnt(cnt2), .cnt_clr(1'b0)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask
    // Called at posedge+1; returns at posedge+1 after the edge that accepted the pair
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic clr, input exp_t e);
        logic rdy;
        in_a = a;
        in_b = b;
        in_valid = 1;
        cnt_clr = clr;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb_q.push_back(e);
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
    endtask
    task automatic idle();
        in_valid = 0;
        cnt_clr = 0;
    endtask
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got out_valid=1 expected no pending pair");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pair", {sign_a, exp_a, sig_a, class_a, sign_b, exp_b, sig_b, class_b}, e);
            end
        end
    end
    localparam exp_t P1 = '{1'b0, 8'h80, 24'h800000, 3'd2, 1'b0, 8'h80, 24'hC90FDB, 3'd2};
    localparam exp_t P2 = '{1'b1, 8'h81, 24'hA00000, 3'd2, 1'b0, 8'h01, 24'h400000, 3'd1};
    localparam exp_t P3 = '{1'b0, 8'hFF, 24'hA00000, 3'd5, 1'b1, 8'h00, 24'h000000, 3'd0};
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cnt", special_cnt, 0);
        chk("rst_data", {sign_a, exp_a, sig_a, class_a, sign_b, exp_b, sig_b, class_b}, 0);
        reset = 0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        send(32'h3F800000, 32'hBF800000, 0, '{1'b0, 8'h7F, 24'h800000, 3'd2, 1'b1, 8'h7F, 24'h800000, 3'd2});
        chk("latency_out_valid", out_valid, 1);
        chk("cnt_norm", special_cnt, 0);
        send(32'h00000001, 32'h00000000, 0, '{1'b0, 8'h01, 24'h000001, 3'd1, 1'b0, 8'h00, 24'h000000, 3'd0});
        send(32'h7F800000, 32'h7FC00000, 0, '{1'b0, 8'hFF, 24'h800000, 3'd3, 1'b0, 8'hFF, 24'hC00000, 3'd4});
        chk("cnt_inf_qnan", special_cnt, 2);
        send(32'h7F800001, 32'h3F800000, 0, '{1'b0, 8'hFF, 24'h800001, 3'd5, 1'b0, 8'h7F, 24'h800000, 3'd2});
        chk("cnt_snan", special_cnt, 3);
        send(32'h7F800000, 32'h7F800000, 0, '{1'b0, 8'hFF, 24'h800000, 3'd3, 1'b0, 8'hFF, 24'h800000, 3'd3});
        chk("cnt_inf_inf", special_cnt, 5);
        send(32'hFF800000, 32'h7FC00000, 1, '{1'b1, 8'hFF, 24'h800000, 3'd3, 1'b0, 8'hFF, 24'hC00000, 3'd4});
        chk("cnt_clr_priority", special_cnt, 0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("drained", out_valid, 0);
        out_ready = 0;
        send(32'h40000000, 32'h40490FDB, 0, P1);
        chk("one_in_ready", in_ready, 1);
        send(32'hC0A00000, 32'h00400000, 0, P2);
        chk("full_in_ready", in_ready, 0);
        in_a = 32'h7FA00000;
        in_b = 32'h80000000;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_head", {exp_a, sig_b}, {8'h80, 24'hC90FDB});
        end
        chk("stall_cnt", special_cnt, 0);
        out_ready = 1;
        send(32'h7FA00000, 32'h80000000, 0, P3);
        chk("cnt_p3", special_cnt, 1);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("p_drained", sb_q.size(), 0);
        chk("sat_ready", rdy2, 1);
        v2 = 1;
        @(posedge clk);
        #1;
        chk("sat_cnt1", cnt2, 2);
        @(posedge clk);
        #1;
        chk("sat_cnt2", cnt2, 3);
        @(posedge clk);
        #1;
        chk("sat_cnt3", cnt2, 3);
        v2 = 0;
        out_ready = 0;
        send(32'h7FC00000, 32'h7F800000, 0, '{1'b0, 8'hFF, 24'hC00000, 3'd4, 1'b0, 8'hFF, 24'h800000, 3'd3});
        send(32'h3F800000, 32'h00000000, 0, '{1'b0, 8'h7F, 24'h800000, 3'd2, 1'b0, 8'h00, 24'h000000, 3'd0});
        idle();
        chk("pre_rst_cnt", special_cnt, 3);
        chk("pre_rst_full", in_ready, 0);
        #3;
        reset = 1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_cnt", special_cnt, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_data", {exp_a, sig_a}, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_no_stale", out_valid, 0);
        @(posedge clk);
        #1;
        chk("post_rst_no_stale2", out_valid, 0);
        chk("final_queue", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
